vga_pixel_pipe: RTL and testbench

//  Pixel back-end downstream of display_controller. Consumes the hCount/vCount/sync outputs of the

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_pixel_pipe_if.sv | 39 +++
 rtl/vga_pixel_pipe_palette_ram.sv | 36 +++
 rtl/vga_pixel_pipe.sv | 118 +++++++++++
 tb/tb_vga_pixel_pipe.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : vga_pkg                                                           |
// | Shared timing constants, framebuffer geometry and swap FSM encoding.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package vga_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_ADDR_W = 17;
    localparam int PIPE_LAT  = 3;

    localparam logic [9:0] H_ACT_START = 10'd144;
    localparam logic [9:0] H_ACT_END   = 10'd783;
    localparam logic [9:0] V_ACT_START = 10'd35;
    localparam logic [9:0] V_ACT_END   = 10'd514;
    localparam logic [9:0] V_SWAP_LINE = 10'd515;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        WAIT = 2'd2
    } swap_state_t;

    // y2*320 + x2 built from two shifts so no multiplier is inferred
    function automatic logic [FB_ADDR_W-1:0] pix_offset(input logic [7:0] y2, input logic [8:0] x2);
        return ({9'd0, y2} << 8) + ({9'd0, y2} << 6) + {8'd0, x2};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : vga_pixel_pipe_if                                               |
// | Timing, framebuffer, palette, swap and pin signals of the pixel back-end.   |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface vga_pixel_pipe_if;
    logic        pix_ce;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync_in;
    logic        vSync_in;
    logic [17:0] fb_addr;
    logic [7:0]  fb_rdata;
    logic        pal_we;
    logic [7:0]  pal_waddr;
    logic [11:0] pal_wdata;
    logic        swap_req;
    logic        swap_ack;
    logic        back_sel;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vgaR;
    logic [3:0]  vgaG;
    logic [3:0]  vgaB;

    modport master (
        output pix_ce, hCount, vCount, hSync_in, vSync_in, fb_rdata,
               pal_we, pal_waddr, pal_wdata, swap_req,
        input  fb_addr, swap_ack, back_sel, vga_hs, vga_vs, vgaR, vgaG, vgaB
    );

    modport slave (
        input  pix_ce, hCount, vCount, hSync_in, vSync_in, fb_rdata,
               pal_we, pal_waddr, pal_wdata, swap_req,
        output fb_addr, swap_ack, back_sel, vga_hs, vga_vs, vgaR, vgaG, vgaB
    );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_pipe_palette_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : palette_ram                                                       |
// | 1W/1R synchronous colour table; a same-clock read sees the old contents.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module palette_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 12,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule
`default_nettype wire

// File: rtl/vga_pixel_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vga_pixel_pipe                                                    |
// | 3-stage framebuffer fetch / palette lookup to VGA pins, with buffer swap.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_pixel_pipe
    import vga_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    vga_pixel_pipe_if.slave bus
);
    logic                 active_w;
    logic [FB_ADDR_W-1:0] offset_w;
    logic                 swap_pt_w;
    logic [11:0]          pal_rgb_w;

    logic [17:0] fb_addr_q, fb_addr_d;
    logic        act0_q, act0_d, hs0_q, hs0_d, vs0_q, vs0_d;
    logic [7:0]  idx_q, idx_d;
    logic        act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic        act2_q, act2_d, hs2_q, hs2_d, vs2_q, vs2_d;

    swap_state_t state_q, state_d;
    logic        front_sel_q, front_sel_d;
    logic        swap_ack_q, swap_ack_d;

    // Outside the active window the offset is forced to 0 so the address never leaves the buffer
    always_comb begin
        active_w = (bus.hCount >= H_ACT_START) && (bus.hCount <= H_ACT_END) &&
                   (bus.vCount >= V_ACT_START) && (bus.vCount <= V_ACT_END);
        offset_w = '0;
        if (active_w)
            offset_w = pix_offset(8'((bus.vCount - V_ACT_START) >> 1),
                                  9'((bus.hCount - H_ACT_START) >> 1));
    end

    always_comb begin
        fb_addr_d = fb_addr_q;
        act0_d = act0_q; hs0_d = hs0_q; vs0_d = vs0_q;
        idx_d  = idx_q;
        act1_d = act1_q; hs1_d = hs1_q; vs1_d = vs1_q;
        act2_d = act2_q; hs2_d = hs2_q; vs2_d = vs2_q;
        if (bus.pix_ce) begin
            fb_addr_d = {front_sel_q, offset_w};
            act0_d = active_w;     hs0_d = bus.hSync_in; vs0_d = bus.vSync_in;
            idx_d  = bus.fb_rdata;
            act1_d = act0_q;       hs1_d = hs0_q;        vs1_d = vs0_q;
            act2_d = act1_q;       hs2_d = hs1_q;        vs2_d = vs1_q;
        end
    end

    // Swap point is the first strobe of the first blank line after the active frame
    assign swap_pt_w = bus.pix_ce && (bus.hCount == 10'd0) && (bus.vCount == V_SWAP_LINE);

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_ack_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.swap_req) state_d = PEND;
            PEND: begin
                if (!bus.swap_req) begin
                    state_d = IDLE;
                end else if (swap_pt_w) begin
                    front_sel_d = ~front_sel_q;
                    swap_ack_d  = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: if (!bus.swap_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_addr_q   <= '0;
            act0_q      <= 1'b0; hs0_q <= 1'b1; vs0_q <= 1'b1;
            idx_q       <= '0;
            act1_q      <= 1'b0; hs1_q <= 1'b1; vs1_q <= 1'b1;
            act2_q      <= 1'b0; hs2_q <= 1'b1; vs2_q <= 1'b1;
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            swap_ack_q  <= 1'b0;
        end else begin
            fb_addr_q   <= fb_addr_d;
            act0_q      <= act0_d; hs0_q <= hs0_d; vs0_q <= vs0_d;
            idx_q       <= idx_d;
            act1_q      <= act1_d; hs1_q <= hs1_d; vs1_q <= vs1_d;
            act2_q      <= act2_d; hs2_q <= hs2_d; vs2_q <= vs2_d;
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_ack_q  <= swap_ack_d;
        end
    end

    palette_ram #(.DEPTH(256), .WIDTH(12), .AW(8)) u_palette (
        .clk   (clk),
        .we    (bus.pal_we),
        .waddr (bus.pal_waddr),
        .wdata (bus.pal_wdata),
        .re    (bus.pix_ce),
        .raddr (idx_q),
        .rdata (pal_rgb_w)
    );

    assign bus.fb_addr  = fb_addr_q;
    assign bus.swap_ack = swap_ack_q;
    assign bus.back_sel = ~front_sel_q;
    assign bus.vga_hs   = hs2_q;
    assign bus.vga_vs   = vs2_q;
    assign bus.vgaR     = act2_q ? pal_rgb_w[11:8] : 4'h0;
    assign bus.vgaG     = act2_q ? pal_rgb_w[7:4]  : 4'h0;
    assign bus.vgaB     = act2_q ? pal_rgb_w[3:0]  : 4'h0;
endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vga_pixel_pipe                                                 |
// | Scoreboard bench for vga_pixel_pipe against a pixel-level reference model.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vga_pixel_pipe;

    typedef struct {
        int addr;
        bit act;
        bit hs;
        bit vs;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    vga_pixel_pipe_if bus();

    vga_pixel_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    item_t      sb[$];
    item_t      inflight[$];
    logic [11:0] pal_m [256];
    logic [7:0]  fb_ovr [int];
    bit          front_m = 1'b0;
    bit          served  = 1'b0;
    bit          ack_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] fb_val(input logic [17:0] a);
        if (fb_ovr.exists(int'(a))) return fb_ovr[int'(a)];
        return 8'((int'(a) * 29) ^ (int'(a) >> 5));
    endfunction

    function automatic bit is_active(input int h, input int v);
        return (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
    endfunction

    function automatic int ref_addr(input bit front, input int h, input int v);
        int off;
        off = is_active(h, v) ? ((v - 35) / 2) * 320 + (h - 144) / 2 : 0;
        return (int'(front) << 17) + off;
    endfunction

    // Synchronous framebuffer BRAM and palette shadow
    always @(posedge clk) bus.fb_rdata <= fb_val(bus.fb_addr);
    always @(posedge clk) if (bus.pal_we) pal_m[bus.pal_waddr] <= bus.pal_wdata;

    // Monitor: each strobe presents a new address and a new pin value
    item_t       mon_cur, mon_old;
    bit          mon_have;
    logic [11:0] mon_rgb;
    always @(posedge clk) begin
        if (reset) begin
            inflight.delete();
        end else if (bus.pix_ce) begin
            mon_have = 1'b0;
            mon_rgb  = 12'h000;
            if (sb.size() == 0) begin
                mon_cur.addr = 0; mon_cur.act = 0; mon_cur.hs = 1; mon_cur.vs = 1;
                chk("sb_underflow", 1, 0);
            end else begin
                mon_cur = sb.pop_front();
            end
            if (inflight.size() >= 2) begin
                mon_old  = inflight.pop_front();
                mon_have = 1'b1;
                mon_rgb  = mon_old.act ? pal_m[fb_val(18'(mon_old.addr))] : 12'h000;
            end
            inflight.push_back(mon_cur);
            #1;
            chk("fb_addr", bus.fb_addr, mon_cur.addr);
            chk("rgb", {bus.vgaR, bus.vgaG, bus.vgaB}, mon_rgb);
            chk("vga_hs", bus.vga_hs, mon_have ? mon_old.hs : 1'b1);
            chk("vga_vs", bus.vga_vs, mon_have ? mon_old.vs : 1'b1);
        end
    end

    always @(negedge clk) begin
        chk("swap_ack", bus.swap_ack, ack_exp);
        chk("back_sel", bus.back_sel, !front_m);
    end

    task automatic send_pix(input int h, input int v, input bit hs, input bit vs,
                            input bit we_ce, input bit we_gap,
                            input logic [7:0] wa, input logic [11:0] wd);
        item_t it;
        bit    swap_now;
        @(posedge clk); #1;
        bus.pix_ce = 1'b1; bus.hCount = 10'(h); bus.vCount = 10'(v);
        bus.hSync_in = hs; bus.vSync_in = vs;
        bus.pal_we = we_ce; bus.pal_waddr = wa; bus.pal_wdata = wd;
        it.addr = ref_addr(front_m, h, v);
        it.act  = is_active(h, v);
        it.hs   = hs;
        it.vs   = vs;
        sb.push_back(it);
        swap_now = (h == 0) && (v == 515) && bus.swap_req && !served;
        @(posedge clk); #1;
        bus.pix_ce = 1'b0; bus.pal_we = 1'b0;
        if (swap_now) begin front_m = !front_m; served = 1'b1; ack_exp = 1'b1; end
        @(posedge clk); #1;
        ack_exp = 1'b0;
        bus.pal_we = we_gap; bus.pal_waddr = wa; bus.pal_wdata = wd;
        @(posedge clk); #1;
        bus.pal_we = 1'b0;
    endtask

    task automatic px(input int h, input int v);
        send_pix(h, v, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 8'h00, 12'h000);
    endtask

    task automatic pal_write(input logic [7:0] a, input logic [11:0] d);
        @(posedge clk); #1;
        bus.pal_we = 1'b1; bus.pal_waddr = a; bus.pal_wdata = d;
        @(posedge clk); #1;
        bus.pal_we = 1'b0;
    endtask

    task automatic set_req(input bit r);
        bus.swap_req = r;
        if (!r) served = 1'b0;
    endtask

    task automatic mid_reset();
        @(posedge clk); #2;
        reset = 1'b1; bus.swap_req = 1'b0; served = 1'b0; front_m = 1'b0; ack_exp = 1'b0;
        #1;
        chk("rst_rgb", {bus.vgaR, bus.vgaG, bus.vgaB}, 12'h000);
        chk("rst_hs", bus.vga_hs, 1'b1);
        chk("rst_vs", bus.vga_vs, 1'b1);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_back_sel", bus.back_sel, 1'b1);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic int pick_h();
        case ($urandom_range(0, 7))
            0: return 0;   1: return 143; 2: return 144; 3: return 145;
            4: return 783; 5: return 784; 6: return 799;
            default: return int'($urandom_range(0, 799));
        endcase
    endfunction

    function automatic int pick_v();
        case ($urandom_range(0, 7))
            0: return 0;   1: return 34;  2: return 35;  3: return 515;
            4: return 514; 5: return 515; 6: return 524;
            default: return int'($urandom_range(0, 524));
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.pix_ce = 0; bus.hCount = 0; bus.vCount = 0; bus.hSync_in = 1; bus.vSync_in = 1;
        bus.pal_we = 0; bus.pal_waddr = 0; bus.pal_wdata = 0; bus.swap_req = 0;
        bus.fb_rdata = 0;
        for (int i = 0; i < 256; i++) pal_write(8'(i), 12'($urandom));
        #1;
        chk("rst_rgb", {bus.vgaR, bus.vgaG, bus.vgaB}, 12'h000);
        chk("rst_hs", bus.vga_hs, 1'b1);
        chk("rst_vs", bus.vga_vs, 1'b1);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_back_sel", bus.back_sel, 1'b1);
        @(posedge clk); #1 reset = 1'b0;

        // Pipeline fill: first outputs stay at reset values
        for (int i = 0; i < 6; i++) px(pick_h(), pick_v());

        // Known pixel (10,7) through a known colour
        fb_ovr[2250] = 8'h05;
        pal_write(8'h05, 12'hF80);
        px(164, 49); px(165, 49); px(164, 50); px(165, 50);

        // Window edges, with index 0xFF mapped to white
        fb_ovr[0] = 8'hFF; fb_ovr[1 << 17] = 8'hFF; fb_ovr[76799] = 8'hFF;
        pal_write(8'hFF, 12'hFFF);
        px(143, 100); px(784, 100); px(300, 34); px(300, 515);
        px(144, 35);  px(783, 514); px(0, 0);

        // Palette write colliding with a read of the same index
        fb_ovr[ref_addr(1'b0, 200, 100)] = 8'h22;
        pal_write(8'h22, 12'h123);
        px(200, 100); px(10, 10);
        send_pix(200, 100, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 12'hABC);
        px(10, 10); px(10, 10); px(10, 10);

        // Swap requested mid-frame, honoured once at the swap line
        px(300, 200);
        set_req(1'b1);
        px(300, 200); px(0, 514); px(5, 515);
        px(0, 515);
        px(400, 300); px(0, 515); px(400, 300);
        set_req(1'b0);
        px(400, 300); px(400, 300);

        // Reset while a swap is pending
        set_req(1'b1);
        px(300, 300);
        mid_reset();
        for (int i = 0; i < 4; i++) px(pick_h(), pick_v());

        // Randomised traffic
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 15) == 0) set_req(!bus.swap_req);
            send_pix(pick_h(), pick_v(), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                     8'($urandom), 12'($urandom));
        end
        for (int i = 0; i < 3; i++) px(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
